// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder controller.
// The master side issues requests; the slave side is the adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, abort, a, b,
      input  ready, busy, done, sum, carry_out
   );

   modport slave (
      input  start, abort, a, b,
      output ready, busy, done, sum, carry_out
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, LSB first, one bit per clock.
//   state | meaning
//   IDLE  | waiting for start; ready=1
//   RUN   | shifting one operand bit pair per edge; busy=1
//   DONE  | one-cycle result strobe; done=1
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   serial_add_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_q;

   logic ha0_s, ha0_c, ha1_s, ha1_c, fa_s, fa_c;
   logic accept, step, finish;

   // Full adder from two half adders and an OR
   assign ha0_s = a_sh[0] ^ b_sh[0];
   assign ha0_c = a_sh[0] & b_sh[0];
   assign ha1_s = ha0_s ^ carry;
   assign ha1_c = ha0_s & carry;
   assign fa_s  = ha1_s;
   assign fa_c  = ha0_c | ha1_c;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // abort wins even on the final bit, so no result is committed
            if (bus.abort) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == LAST) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         psum   <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
         end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= {fa_s, psum[WIDTH-1:1]};
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (finish) begin
               sum_q  <= {fa_s, psum[WIDTH-1:1]};
               cout_q <= fa_c;
            end
         end
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
endmodule
